// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared widths, reset PC, instruction length and FSM state encoding
package pc_sequencer_pkg;
   localparam int          CPU_WIDTH  = 32;
   localparam logic [31:0] RESET_PC   = 32'h8000_0000;
   localparam int          CNT_WIDTH  = 32;
   localparam int          INST_BYTES = 4;
   typedef enum logic [1:0] {
      PCS_BOOT = 2'd0,
      PCS_REQ  = 2'd1,
      PCS_EXEC = 2'd2
   } pcs_e;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: priority next-PC select (trap > branch > jump > pc+4) with alignment mask and misalign detect
module pc_next_mux #(
   parameter int W = pc_sequencer_pkg::CPU_WIDTH
) (
   input  logic [W-1:0] pc,
   input  logic         trap,
   input  logic [W-1:0] trap_vec,
   input  logic         br_taken,
   input  logic [W-1:0] br_target,
   input  logic         jump,
   input  logic [W-1:0] jump_target,
   output logic [W-1:0] next_pc,
   output logic         misalign
);
   import pc_sequencer_pkg::*;
   logic [W-1:0] tgt;
   logic         redirect;
   always_comb begin
      redirect = trap | br_taken | jump;
      tgt      = trap ? trap_vec : br_taken ? br_target : jump_target;
      next_pc  = redirect ? {tgt[W-1:2], 2'b00} : pc + W'(INST_BYTES);
      misalign = redirect & (tgt[1:0] != 2'b00);
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC stage with fetch request handshake, commit-driven next-PC, retired counter and sticky misalign flag
module pc_sequencer #(
   parameter int                    CPU_WIDTH = pc_sequencer_pkg::CPU_WIDTH,
   parameter logic [CPU_WIDTH-1:0]  RESET_PC  = pc_sequencer_pkg::RESET_PC,
   parameter int                    CNT_WIDTH = pc_sequencer_pkg::CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rstn,
   output logic                 fetch_valid,
   input  logic                 fetch_ready,
   output logic [CPU_WIDTH-1:0] pc,
   input  logic                 commit_valid,
   output logic                 commit_ready,
   input  logic                 br_taken,
   input  logic [CPU_WIDTH-1:0] br_target,
   input  logic                 jump,
   input  logic [CPU_WIDTH-1:0] jump_target,
   input  logic                 trap,
   input  logic [CPU_WIDTH-1:0] trap_vec,
   output logic [CNT_WIDTH-1:0] inst_cnt,
   output logic                 misalign_err
);
   import pc_sequencer_pkg::*;
   pcs_e                 state_q, state_d;
   logic [CPU_WIDTH-1:0] pc_q, pc_d, next_pc;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d, misalign, commit;

   pc_next_mux #(.W(CPU_WIDTH)) u_mux (
      .pc          (pc_q),
      .trap        (trap),
      .trap_vec    (trap_vec),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .next_pc     (next_pc),
      .misalign    (misalign)
   );

   always_comb begin
      commit = (state_q == PCS_EXEC) & commit_valid;
      case (state_q)
         PCS_BOOT: state_d = PCS_REQ;
         PCS_REQ:  state_d = fetch_ready ? PCS_EXEC : PCS_REQ;
         PCS_EXEC: state_d = commit_valid ? PCS_REQ : PCS_EXEC;
         default:  state_d = PCS_REQ;
      endcase
      pc_d  = commit ? next_pc : pc_q;
      cnt_d = cnt_q + CNT_WIDTH'(commit);
      err_d = err_q | (commit & misalign);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= PCS_BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign fetch_valid  = state_q == PCS_REQ;
   assign commit_ready = state_q == PCS_EXEC;
   assign pc           = pc_q;
   assign inst_cnt     = cnt_q;
   assign misalign_err = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus, per-cycle reference model compare, and literal checks pinning the model
module tb_pc_sequencer;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        fetch_valid, fetch_ready = 1'b0;
   logic [31:0] pc;
   logic        commit_valid = 1'b0, commit_ready;
   logic        br_taken = 1'b0, jump = 1'b0, trap = 1'b0;
   logic [31:0] br_target = '0, jump_target = '0, trap_vec = '0;
   logic [31:0] inst_cnt;
   logic        misalign_err;
   int          n_chk = 0, n_pass = 0;

   pc_sequencer dut (
      .clk(clk), .rstn(rstn), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .pc(pc),
      .commit_valid(commit_valid), .commit_ready(commit_ready), .br_taken(br_taken),
      .br_target(br_target), .jump(jump), .jump_target(jump_target), .trap(trap),
      .trap_vec(trap_vec), .inst_cnt(inst_cnt), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: awaiting_fetch / awaiting_commit phases tracked as plain flags
   bit          m_booting, m_want_fetch, m_want_commit;
   logic [31:0] m_pc, m_cnt, m_tgt;
   bit          m_err, m_redir;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_booting = 1; m_want_fetch = 0; m_want_commit = 0;
         m_pc = 32'h8000_0000; m_cnt = 0; m_err = 0;
      end else if (m_booting) begin
         m_booting = 0; m_want_fetch = 1;
      end else if (m_want_fetch) begin
         if (fetch_ready) begin m_want_fetch = 0; m_want_commit = 1; end
      end else if (m_want_commit && commit_valid) begin
         m_redir = trap || br_taken || jump;
         m_tgt   = trap ? trap_vec : (br_taken ? br_target : jump_target);
         if (m_redir && (m_tgt % 4) != 0) m_err = 1;
         m_pc  = m_redir ? m_tgt - (m_tgt % 4) : m_pc + 4;
         m_cnt = m_cnt + 1;
         m_want_commit = 0; m_want_fetch = 1;
      end
   end

   always @(negedge clk) begin
      check("cyc_fetch_valid", fetch_valid, m_want_fetch);
      check("cyc_commit_ready", commit_ready, m_want_commit);
      check("cyc_pc", pc, m_pc);
      check("cyc_inst_cnt", inst_cnt, m_cnt);
      check("cyc_misalign", misalign_err, m_err);
   end

   task automatic do_req();
      int n = 0;
      while (!fetch_valid && n < 20) begin @(negedge clk); n++; end
      check("req_wait", fetch_valid, 1);
      fetch_ready = 1'b1;
      @(negedge clk);
      fetch_ready = 1'b0;
   endtask

   task automatic do_commit(input logic t, input logic b, input logic j,
                            input logic [31:0] tv, input logic [31:0] bt, input logic [31:0] jt);
      int n = 0;
      while (!commit_ready && n < 20) begin @(negedge clk); n++; end
      check("commit_wait", commit_ready, 1);
      trap = t; br_taken = b; jump = j; trap_vec = tv; br_target = bt; jump_target = jt;
      commit_valid = 1'b1;
      @(negedge clk);
      commit_valid = 1'b0; trap = 0; br_taken = 0; jump = 0;
      trap_vec = '0; br_target = '0; jump_target = '0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_pc", pc, 32'h8000_0000);
      check("rst_fv", fetch_valid, 0);
      check("rst_cr", commit_ready, 0);
      check("rst_cnt", inst_cnt, 0);
      check("rst_err", misalign_err, 0);
      #2 rstn = 1'b1;
      #1 check("boot_fv", fetch_valid, 0);
      @(negedge clk);
      check("req_fv", fetch_valid, 1);
      repeat (5) begin
         check("stall_fv", fetch_valid, 1);
         check("stall_pc", pc, 32'h8000_0000);
         @(negedge clk);
      end
      do_req();
      check("exec_cr", commit_ready, 1);
      check("exec_fv", fetch_valid, 0);
      do_commit(0, 0, 0, 0, 0, 0);
      check("seq_pc1", pc, 32'h8000_0004);
      do_req(); do_commit(0, 0, 0, 0, 0, 0);
      check("seq_pc2", pc, 32'h8000_0008);
      do_req(); do_commit(0, 0, 0, 0, 0, 0);
      check("seq_pc3", pc, 32'h8000_000C);
      check("seq_cnt", inst_cnt, 3);
      trap = 1'b1; trap_vec = 32'h8000_0101; commit_valid = 1'b1;
      repeat (2) @(negedge clk);
      commit_valid = 1'b0; trap = 1'b0; trap_vec = '0;
      check("req_commit_pc", pc, 32'h8000_000C);
      check("req_commit_cnt", inst_cnt, 3);
      check("req_commit_err", misalign_err, 0);
      do_req(); do_commit(1, 1, 1, 32'h8000_0100, 32'h8000_0202, 32'h8000_0300);
      check("prio_trap", pc, 32'h8000_0100);
      check("prio_trap_err", misalign_err, 0);
      do_req(); do_commit(0, 1, 1, 0, 32'h8000_0200, 32'h8000_0301);
      check("prio_br", pc, 32'h8000_0200);
      check("prio_br_err", misalign_err, 0);
      do_req(); do_commit(0, 0, 1, 0, 0, 32'h8000_0300);
      check("prio_jump", pc, 32'h8000_0300);
      do_req(); do_commit(0, 0, 1, 0, 0, 32'h8000_0302);
      check("mis_pc", pc, 32'h8000_0300);
      check("mis_err", misalign_err, 1);
      do_req(); do_commit(0, 0, 0, 0, 0, 0);
      check("mis_sticky_pc", pc, 32'h8000_0304);
      check("mis_sticky", misalign_err, 1);
      do_req(); do_commit(0, 0, 1, 0, 0, 32'hFFFF_FFFC);
      check("top_pc", pc, 32'hFFFF_FFFC);
      do_req(); do_commit(0, 0, 0, 0, 0, 0);
      check("wrap_pc", pc, 32'h0000_0000);
      check("wrap_cnt", inst_cnt, 10);
      do_req();
      check("pre_rst_cr", commit_ready, 1);
      #2 rstn = 1'b0;
      #1;
      check("arst_pc", pc, 32'h8000_0000);
      check("arst_cr", commit_ready, 0);
      check("arst_fv", fetch_valid, 0);
      check("arst_cnt", inst_cnt, 0);
      check("arst_err", misalign_err, 0);
      @(negedge clk);
      #2 rstn = 1'b1;
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
